// File: rtl/msd_pkg.sv
// Shared types and constants for the sequential tens/units splitter.
// Holds the FSM state encoding and the decimal digit constants.
package msd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } msd_state_t;

    localparam int TEN     = 10;
    localparam int DIGIT_W = 4;

endpackage : msd_pkg

// File: rtl/msd_sub_step.sv
// One conditional subtract-ten step of the splitter.
// rem_next equals rem-10 when rem>=10, otherwise rem unchanged.
module msd_sub_step
    import msd_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_rem,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_ge10
);

    localparam logic [WIDTH-1:0] TEN_W = WIDTH'(TEN);

    logic w_ge10;

    assign w_ge10     = (i_rem >= TEN_W);
    assign o_ge10     = w_ge10;
    assign o_rem_next = w_ge10 ? (i_rem - TEN_W) : i_rem;

endmodule : msd_sub_step

// File: rtl/msd_seq_ctrl.sv
// Sequential tens/units splitter: subtracts ten once per clock and hands
// tens, units and the most-significant decimal digit to the sink.
module msd_seq_ctrl
    import msd_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic [DIGIT_W-1:0] msd,
    output logic               busy
);

    msd_state_t         r_state;
    logic [WIDTH-1:0]   r_rem;
    logic [DIGIT_W-1:0] r_tcnt;
    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_units;
    logic [DIGIT_W-1:0] r_msd;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_rem_next;
    logic               w_ge10;

    msd_sub_step #(
        .WIDTH (WIDTH)
    ) u_sub_step (
        .i_rem      (r_rem),
        .o_rem_next (w_rem_next),
        .o_ge10     (w_ge10)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_tcnt      <= '0;
            r_tens      <= '0;
            r_units     <= '0;
            r_msd       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rem   <= in_value;
                        r_tcnt  <= '0;
                        r_state <= SUB;
                    end
                end
                SUB: begin
                    if (w_ge10) begin
                        r_rem  <= w_rem_next;
                        r_tcnt <= r_tcnt + 1'b1;
                    end else begin
                        // rem<10 here, so its low nibble is the units digit
                        r_tens      <= r_tcnt;
                        r_units     <= r_rem[DIGIT_W-1:0];
                        r_msd       <= (r_tcnt != '0) ? r_tcnt : r_rem[DIGIT_W-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on state only, never on in_valid/out_ready.
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == SUB) || (r_state == DONE);
    assign out_valid = r_out_valid;
    assign tens      = r_tens;
    assign units     = r_units;
    assign msd       = r_msd;

endmodule : msd_seq_ctrl
